// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding and compare-swap schedule for sort_core
package sort_pkg;
   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
   localparam int NUM_ELEMS = 4;
   localparam logic [2:0] LAST_STEP = 3'd5;
   localparam logic [1:0] PAIR_0_1 = 2'd0;
   localparam logic [1:0] PAIR_1_2 = 2'd1;
   localparam logic [1:0] PAIR_2_3 = 2'd2;
   // lower index of the pair compared at each bubble-sort step: 01,12,23,01,12,01
   function automatic logic [1:0] pair_lo(input logic [2:0] s);
      return (s == 3'd1 || s == 3'd4) ? PAIR_1_2 : (s == 3'd2) ? PAIR_2_3 : PAIR_0_1;
   endfunction
endpackage

// File: rtl/compare_swap.sv
// compare_swap: orders one pair, lo_out takes the lower-index position
module compare_swap #(
   parameter int WIDTH = 4,
   parameter bit DESCENDING = 1'b0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lo_out,
   output logic [WIDTH-1:0] hi_out
);
   logic swap;
   always_comb begin
      swap = DESCENDING ? (a < b) : (a > b);
      lo_out = swap ? b : a;
      hi_out = swap ? a : b;
   end
endmodule

// File: rtl/sort_core.sv
// sort_core: four-entry sequential bubble sorter, one compare-swap per clock
module sort_core
   import sort_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter bit DESCENDING = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_num0,
   input  logic [WIDTH-1:0] in_num1,
   input  logic [WIDTH-1:0] in_num2,
   input  logic [WIDTH-1:0] in_num3,
   output logic             busy,
   output logic [WIDTH-1:0] sorted_num0,
   output logic [WIDTH-1:0] sorted_num1,
   output logic [WIDTH-1:0] sorted_num2,
   output logic [WIDTH-1:0] sorted_num3,
   output logic             start_display
);
   state_t state, state_nxt;
   logic [2:0] step;
   logic [WIDTH-1:0] w [NUM_ELEMS];
   logic [1:0] lo;
   logic [WIDTH-1:0] cs_lo, cs_hi;

   compare_swap #(.WIDTH(WIDTH), .DESCENDING(DESCENDING)) u_cs (
      .a(w[lo]),
      .b(w[lo + 2'd1]),
      .lo_out(cs_lo),
      .hi_out(cs_hi)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         step <= '0;
         for (int i = 0; i < NUM_ELEMS; i++) w[i] <= '0;
         sorted_num0 <= '0;
         sorted_num1 <= '0;
         sorted_num2 <= '0;
         sorted_num3 <= '0;
         start_display <= 1'b0;
      end else begin
         state <= state_nxt;
         start_display <= (state == DONE);
         if (state == IDLE && start) begin
            w[0] <= in_num0;
            w[1] <= in_num1;
            w[2] <= in_num2;
            w[3] <= in_num3;
            step <= '0;
         end
         if (state == SORT) begin
            w[lo] <= cs_lo;
            w[lo + 2'd1] <= cs_hi;
            step <= (step == LAST_STEP) ? 3'd0 : step + 3'd1;
         end
         // results only move here, so the display stage sees a stable value during the next sort
         if (state == DONE) begin
            sorted_num0 <= w[0];
            sorted_num1 <= w[1];
            sorted_num2 <= w[2];
            sorted_num3 <= w[3];
         end
      end
   end

   always_comb begin
      state_nxt = (state == IDLE) ? (start ? SORT : IDLE) :
                  (state == SORT) ? ((step == LAST_STEP) ? DONE : SORT) : IDLE;
   end

   always_comb begin
      busy = (state != IDLE);
      lo = pair_lo(step);
   end
endmodule

// File: doc/sort_core.md
Name: sort_core

Overview:
- Four-entry sequential sorter that sits directly upstream of the display-sequencing stage.
- On a start request it captures four unsigned numbers and sorts them with a fixed 6-step bubble-sort schedule, one compare-swap per clock.
- It registers the result on sorted_num0..3, where sorted_num0 is the smallest for ascending order.
- It then pulses start_display for one cycle so the display stage begins cycling the sorted values.

Parameters:
- WIDTH, 4, bit width of each number (unsigned).
- DESCENDING, 0, 0 = ascending (sorted_num0 smallest), 1 = descending (sorted_num0 largest).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  sort request, sampled only in IDLE.
- in_num0  input  WIDTH  unsorted input 0.
- in_num1  input  WIDTH  unsorted input 1.
- in_num2  input  WIDTH  unsorted input 2.
- in_num3  input  WIDTH  unsorted input 3.
- busy  output  1  high whenever state is not IDLE.
- sorted_num0  output  WIDTH  sorted result, position 0.
- sorted_num1  output  WIDTH  sorted result, position 1.
- sorted_num2  output  WIDTH  sorted result, position 2.
- sorted_num3  output  WIDTH  sorted result, position 3.
- start_display  output  1  one-cycle pulse: result valid, display may start.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, step = 0.
  - Working registers w0..w3 = 0.
  - sorted_num0..3 = 0.
  - start_display = 0, busy = 0.
- States: IDLE, SORT, DONE.
- IDLE:
  - On the edge where start=1 (call it E0): w0..w3 <= in_num0..3, step <= 0, state <= SORT.
  - start=0: hold.
- SORT:
  - Each edge E1..E6 performs one compare-swap selected by step.
  - Pair schedule for step 0..5: (w0,w1), (w1,w2), (w2,w3), (w0,w1), (w1,w2), (w0,w1).
  - Ascending: swap only if the lower-index value is strictly greater than the upper.
  - Descending: swap only if strictly less.
  - Equal values never swap.
  - step increments each edge. At E6 (step==5) state <= DONE and step <= 0.
- DONE:
  - At edge E7: sorted_num0..3 <= w0..w3, start_display <= 1, state <= IDLE.
  - start_display is high for exactly the cycle between E7 and E8, then returns to 0.
- Latency: result and pulse visible 7 edges after the start-sampling edge. Fixed, independent of data.
- busy: registered from state. High from after E0 through E7; low in the cycle start_display is high.
- Throughput: back-to-back starts allowed. A start high during the start_display cycle is accepted at E8.
- Output hold: sorted_num0..3 change only at a DONE edge and hold the previous result during a new sort. The downstream stage may keep reading them while a new sort runs.
- start while busy: ignored and not queued. in_num changes after E0 have no effect on the running sort.
- Arithmetic: comparisons are unsigned WIDTH-bit. No width growth, no overflow possible.
- Reset mid-SORT or mid-DONE: all registers return to reset values immediately. No start_display pulse for the aborted sort. The first start sampled after rst deasserts begins a fresh sort.
- start held high continuously: a new sort begins every 8 edges, with a start_display pulse each time.

Decomposition:
- Package sort_pkg:
  - state encoding (IDLE/SORT/DONE).
  - NUM_ELEMS = 4.
  - LAST_STEP = 5.
  - pair-index constants for the 6-step schedule.
- One natural sub-module: compare_swap.
  - Purely combinational.
  - Parameters WIDTH and DESCENDING.
  - Inputs a, b; outputs lo_out, hi_out in the requested order.
  - Instantiated once, muxed by step.

Test Plan:
- Ascending sort: reset, then start pulse with in_num = 9,3,7,1 at E0 -> sorted_num0..3 = 1,3,7,9 after E7; start_display high for exactly one cycle; busy low in that cycle.
- Duplicates and already sorted: inputs 5,5,0,5 -> 0,5,5,5. Then inputs 1,2,3,4 -> 1,2,3,4. Latency is 7 edges in both cases; previous outputs hold during the second sort.
- Reverse order, descending build: inputs 12,13,14,15 with DESCENDING=1 -> 15,14,13,12. Inputs 15,0,15,0 with DESCENDING=0 -> 0,0,15,15.
- Start while busy: start at E0 with 8,6,4,2; start again at E3 with 1,1,1,1 -> output 2,4,6,8; exactly one start_display pulse; no second sort.
- Reset mid-sort: assert rst between E3 and E4 -> all outputs 0 and busy 0 immediately; no pulse. A start after release with 3,2,1,0 -> 0,1,2,3 at 7-edge latency.
- Continuous start high: inputs 2,1,0,3 -> start_display pulses every 8 edges; outputs stable at 0,1,2,3.
